// File: rtl/alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Initiator side of the ALU action interface for one RMT action stage.
// Accepts one PHV with its action word and tenant id, selects the ALU
// operands from PHV containers, and looks up the tenant page-table entry. It
// then issues the action to a single ALU, collects the ALU result into the
// destination container, and hands the updated PHV downstream. Only one
// transaction is in flight at a time.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   phv_in / action_word_in /
//   vid_in / phv_in_valid /
//   phv_in_ready                   upstream PHV + action handshake
//   cfg_wr_en / cfg_wr_addr /
//   cfg_wr_data                    tenant page-table write port
//   action_out / action_valid /
//   operand_{1,2,3}_out /
//   alu_ready                      action issue to the ALU
//   page_tbl_out /
//   page_tbl_out_valid             tenant {addr_len, base_addr} to the ALU
//   alu_result / alu_result_valid /
//   alu_ready_in                   result return from the ALU
//   phv_out / phv_out_valid /
//   phv_out_ready                  downstream PHV handshake
//   action_err                     one-cycle pulse on an illegal container index
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
   parameter int ACTION_LEN = 64,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CONT   = 8,
   parameter int NUM_TENANT = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_CONT*DATA_WIDTH-1:0] phv_in,
   input  logic [ACTION_LEN-1:0]          action_word_in,
   input  logic [3:0]                     vid_in,
   input  logic                           phv_in_valid,
   output logic                           phv_in_ready,
   input  logic                           cfg_wr_en,
   input  logic [3:0]                     cfg_wr_addr,
   input  logic [15:0]                    cfg_wr_data,
   output logic [ACTION_LEN-1:0]          action_out,
   output logic                           action_valid,
   output logic [DATA_WIDTH-1:0]          operand_1_out,
   output logic [DATA_WIDTH-1:0]          operand_2_out,
   output logic [DATA_WIDTH-1:0]          operand_3_out,
   input  logic                           alu_ready,
   output logic [15:0]                    page_tbl_out,
   output logic                           page_tbl_out_valid,
   input  logic [DATA_WIDTH-1:0]          alu_result,
   input  logic                           alu_result_valid,
   output logic                           alu_ready_in,
   output logic [NUM_CONT*DATA_WIDTH-1:0] phv_out,
   output logic                           phv_out_valid,
   input  logic                           phv_out_ready,
   output logic                           action_err
);

   localparam int PHV_W = NUM_CONT * DATA_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_OUT   = 2'd3
   } state_t;

   state_t state;
   state_t state_next;

   logic [PHV_W-1:0]      phv_reg;
   logic [ACTION_LEN-1:0] action_reg;
   logic [DATA_WIDTH-1:0] operand_1_reg;
   logic [DATA_WIDTH-1:0] operand_2_reg;
   logic [DATA_WIDTH-1:0] operand_3_reg;
   logic [15:0]           page_tbl_reg;
   logic [4:0]            dst_reg;
   logic                  err_reg;
   logic [15:0]           page_tbl [NUM_TENANT];

   // Field decode of the incoming action word.
   logic [7:0]  op;
   logic [4:0]  src1;
   logic [4:0]  src2;
   logic [4:0]  dst;
   logic [15:0] imm16;
   logic        op_imm;
   logic        op_noop;
   logic        idx_illegal;
   logic        accept;

   assign op    = action_word_in[ACTION_LEN-1  -: 8];
   assign src1  = action_word_in[ACTION_LEN-9  -: 5];
   assign src2  = action_word_in[ACTION_LEN-14 -: 5];
   assign dst   = action_word_in[ACTION_LEN-19 -: 5];
   assign imm16 = action_word_in[ACTION_LEN-24 -: 16];

   function automatic logic is_imm_op(input logic [7:0] opcode);
      return (opcode == 8'h09) || (opcode == 8'h0A) || (opcode == 8'h0E) ||
             (opcode == 8'h08) || (opcode == 8'h0B) || (opcode == 8'h07);
   endfunction

   function automatic logic idx_bad(input logic [4:0] idx);
      return 32'(idx) >= 32'(NUM_CONT);
   endfunction

   // Out-of-range indices read as zero; such actions never reach the ALU.
   function automatic logic [DATA_WIDTH-1:0] sel_cont(input logic [PHV_W-1:0] phv,
                                                      input logic [4:0]       idx);
      logic [DATA_WIDTH-1:0] v;
      v = '0;
      for (int k = 0; k < NUM_CONT; k++) begin
         if (idx == 5'(k)) v = phv[k*DATA_WIDTH +: DATA_WIDTH];
      end
      return v;
   endfunction

   assign op_imm      = is_imm_op(op);
   assign op_noop     = (op == 8'h00);
   // src2 only counts as used when the operand does not come from imm16.
   assign idx_illegal = idx_bad(src1) || idx_bad(dst) || (!op_imm && idx_bad(src2));
   assign accept      = (state == S_IDLE) && phv_in_valid;

   // State register, capture registers and page table.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         phv_reg       <= '0;
         action_reg    <= '0;
         operand_1_reg <= '0;
         operand_2_reg <= '0;
         operand_3_reg <= '0;
         page_tbl_reg  <= '0;
         dst_reg       <= '0;
         err_reg       <= 1'b0;
         for (int t = 0; t < NUM_TENANT; t++) page_tbl[t] <= '0;
      end else begin
         state   <= state_next;
         err_reg <= accept && !op_noop && idx_illegal;

         if (cfg_wr_en) page_tbl[cfg_wr_addr] <= cfg_wr_data;

         // Everything the ALU sees is frozen here until the next accept, so
         // later cfg writes or input changes cannot disturb its RAM address.
         if (accept) begin
            phv_reg       <= phv_in;
            action_reg    <= action_word_in;
            operand_1_reg <= sel_cont(phv_in, src1);
            operand_2_reg <= op_imm ? {{(DATA_WIDTH-16){1'b0}}, imm16}
                                    : sel_cont(phv_in, src2);
            operand_3_reg <= sel_cont(phv_in, dst);
            page_tbl_reg  <= page_tbl[vid_in];
            dst_reg       <= dst;
         end

         if ((state == S_WAIT) && alu_result_valid) begin
            for (int k = 0; k < NUM_CONT; k++) begin
               if (dst_reg == 5'(k)) phv_reg[k*DATA_WIDTH +: DATA_WIDTH] <= alu_result;
            end
         end
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      state_next         = state;
      phv_in_ready       = 1'b0;
      action_valid       = 1'b0;
      alu_ready_in       = 1'b0;
      phv_out_valid      = 1'b0;
      page_tbl_out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            phv_in_ready = 1'b1;
            if (phv_in_valid) state_next = (op_noop || idx_illegal) ? S_OUT : S_ISSUE;
         end
         S_ISSUE: begin
            page_tbl_out_valid = 1'b1;
            action_valid       = alu_ready;
            if (alu_ready) state_next = S_WAIT;
         end
         S_WAIT: begin
            page_tbl_out_valid = 1'b1;
            alu_ready_in       = 1'b1;
            if (alu_result_valid) state_next = S_OUT;
         end
         S_OUT: begin
            phv_out_valid = 1'b1;
            if (phv_out_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   assign action_out    = action_reg;
   assign operand_1_out = operand_1_reg;
   assign operand_2_out = operand_2_reg;
   assign operand_3_out = operand_3_reg;
   assign page_tbl_out  = page_tbl_reg;
   assign phv_out       = phv_reg;
   assign action_err    = err_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. The bench plays the upstream source,
// the ALU and the downstream sink. Expected values come from a transaction-
// level model: field extraction, operand choice, a tenant table array, and
// the PHV with the destination container replaced.
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

   logic         clk;
   logic         rst_n;
   logic [255:0] phv_in;
   logic [63:0]  action_word_in;
   logic [3:0]   vid_in;
   logic         phv_in_valid;
   logic         phv_in_ready;
   logic         cfg_wr_en;
   logic [3:0]   cfg_wr_addr;
   logic [15:0]  cfg_wr_data;
   logic [63:0]  action_out;
   logic         action_valid;
   logic [31:0]  operand_1_out;
   logic [31:0]  operand_2_out;
   logic [31:0]  operand_3_out;
   logic         alu_ready;
   logic [15:0]  page_tbl_out;
   logic         page_tbl_out_valid;
   logic [31:0]  alu_result;
   logic         alu_result_valid;
   logic         alu_ready_in;
   logic [255:0] phv_out;
   logic         phv_out_valid;
   logic         phv_out_ready;
   logic         action_err;

   int n_tests = 0;
   int n_fail  = 0;
   int issue_cnt = 0;
   int err_cnt   = 0;

   logic [15:0] pt_model [16];
   logic [7:0]  ops [11] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h05, 8'h07,
                             8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0E};

   alu_issue_ctrl dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .phv_in             (phv_in),
      .action_word_in     (action_word_in),
      .vid_in             (vid_in),
      .phv_in_valid       (phv_in_valid),
      .phv_in_ready       (phv_in_ready),
      .cfg_wr_en          (cfg_wr_en),
      .cfg_wr_addr        (cfg_wr_addr),
      .cfg_wr_data        (cfg_wr_data),
      .action_out         (action_out),
      .action_valid       (action_valid),
      .operand_1_out      (operand_1_out),
      .operand_2_out      (operand_2_out),
      .operand_3_out      (operand_3_out),
      .alu_ready          (alu_ready),
      .page_tbl_out       (page_tbl_out),
      .page_tbl_out_valid (page_tbl_out_valid),
      .alu_result         (alu_result),
      .alu_result_valid   (alu_result_valid),
      .alu_ready_in       (alu_ready_in),
      .phv_out            (phv_out),
      .phv_out_valid      (phv_out_valid),
      .phv_out_ready      (phv_out_ready),
      .action_err         (action_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (action_valid) issue_cnt++;
      if (action_err)   err_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got=running exp=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mk_aw(input logic [7:0] op, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [4:0] d,
                                         input logic [15:0] imm);
      return {op, s1, s2, d, imm, 25'($urandom)};
   endfunction

   function automatic logic [31:0] cont(input logic [255:0] p, input logic [4:0] idx);
      return (idx < 5'd8) ? p[int'(idx)*32 +: 32] : 32'h0;
   endfunction

   task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
      @(negedge clk);
      cfg_wr_en = 1'b0;
      pt_model[a] = d;
   endtask

   // One full transaction. d = cycles alu_ready stays low in ISSUE,
   // r = cycles from issue to result (r=2 models a 2-cycle ALU),
   // stall = cycles phv_out_ready stays low, cfg_mid = rewrite the active
   // tenant entry during WAIT.
   task automatic txn(input logic [255:0] phv, input logic [63:0] aw, input logic [3:0] vid,
                      input int d, input int r, input int stall, input bit cfg_mid);
      logic [7:0]   op;
      logic [4:0]   s1, s2, ds;
      logic [15:0]  imm, exp_pt;
      logic         is_imm, bad, noop;
      logic [31:0]  e1, e2, e3, res;
      logic [255:0] exp_phv;
      int           iss0, err0;
      op  = aw[63:56]; s1 = aw[55:51]; s2 = aw[50:46]; ds = aw[45:41]; imm = aw[40:25];
      is_imm = op inside {8'h09, 8'h0A, 8'h0E, 8'h08, 8'h0B, 8'h07};
      noop   = (op == 8'h00);
      bad    = !noop && (s1 >= 5'd8 || ds >= 5'd8 || (!is_imm && s2 >= 5'd8));
      e1 = cont(phv, s1);
      e2 = is_imm ? {16'h0, imm} : cont(phv, s2);
      e3 = cont(phv, ds);
      res = e1 + e2;

      @(negedge clk);
      chk("idle_in_ready", phv_in_ready, 1);
      chk("idle_out_valid", phv_out_valid, 0);
      phv_in = phv; action_word_in = aw; vid_in = vid; phv_in_valid = 1'b1;
      alu_ready = (d == 0);
      #1 chk("idle_no_issue", action_valid, 0);
      iss0 = issue_cnt; err0 = err_cnt; exp_pt = pt_model[vid];

      @(negedge clk);
      phv_in_valid = 1'b0;
      phv_in = {8{$urandom}}; action_word_in = {$urandom, $urandom}; vid_in = 4'($urandom);
      if (noop || bad) begin
         exp_phv = phv;
         alu_ready = 1'b1;
      end else begin
         for (int k = 0; k < d; k++) begin
            chk("stall_no_issue", action_valid, 0);
            chk("stall_pt_valid", page_tbl_out_valid, 1);
            chk("stall_op1", operand_1_out, e1);
            alu_result = $urandom; alu_result_valid = 1'b1;
            @(negedge clk);
         end
         alu_result_valid = 1'b0; alu_ready = 1'b1;
         #1;
         chk("issue_valid", action_valid, 1);
         chk("issue_action", action_out, aw);
         chk("issue_op1", operand_1_out, e1);
         chk("issue_op2", operand_2_out, e2);
         chk("issue_op3", operand_3_out, e3);
         chk("issue_pt", page_tbl_out, exp_pt);
         chk("issue_pt_valid", page_tbl_out_valid, 1);
         chk("issue_out_valid", phv_out_valid, 0);
         for (int k = 1; k <= r; k++) begin
            @(negedge clk);
            cfg_wr_en = 1'b0;
            chk("wait_no_issue", action_valid, 0);
            chk("wait_ready_in", alu_ready_in, 1);
            chk("wait_out_valid", phv_out_valid, 0);
            chk("wait_pt_valid", page_tbl_out_valid, 1);
            chk("wait_pt_hold", page_tbl_out, exp_pt);
            chk("wait_action_hold", action_out, aw);
            chk("wait_op2_hold", operand_2_out, e2);
            if (k == 1 && cfg_mid) begin
               cfg_wr_en = 1'b1; cfg_wr_addr = vid; cfg_wr_data = 16'($urandom);
               pt_model[vid] = cfg_wr_data;
            end
            if (k == r) begin
               alu_result = res; alu_result_valid = 1'b1;
            end
         end
         @(negedge clk);
         cfg_wr_en = 1'b0; alu_result_valid = 1'b0;
         exp_phv = phv;
         exp_phv[int'(ds)*32 +: 32] = res;
      end

      for (int k = 0; k <= stall; k++) begin
         chk("out_valid", phv_out_valid, 1);
         chk("out_phv", phv_out, exp_phv);
         chk("out_err", action_err, (bad && k == 0));
         chk("out_no_issue", action_valid, 0);
         chk("out_pt_valid", page_tbl_out_valid, 0);
         phv_out_ready = (k == stall);
         @(negedge clk);
      end
      phv_out_ready = 1'b0; alu_ready = 1'b0;
      chk("done_out_valid", phv_out_valid, 0);
      chk("done_in_ready", phv_in_ready, 1);
      chk("issue_count", 32'(issue_cnt - iss0), (noop || bad) ? 0 : 1);
      chk("err_count", 32'(err_cnt - err0), bad ? 1 : 0);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, phv_in_ready, 1);
      chk({tag, "_action"}, action_out, 0);
      chk({tag, "_act_valid"}, action_valid, 0);
      chk({tag, "_ops"}, {operand_1_out, operand_2_out, operand_3_out}, 0);
      chk({tag, "_pt"}, {page_tbl_out, page_tbl_out_valid}, 0);
      chk({tag, "_ready_in"}, alu_ready_in, 0);
      chk({tag, "_phv_out"}, phv_out, 0);
      chk({tag, "_out_valid"}, phv_out_valid, 0);
      chk({tag, "_err"}, action_err, 0);
   endtask

   task automatic reset_in_wait();
      logic [255:0] p;
      p = {8{$urandom}};
      @(negedge clk);
      phv_in = p; action_word_in = mk_aw(8'h01, 5'd1, 5'd2, 5'd3, 16'h0); vid_in = 4'd5;
      phv_in_valid = 1'b1; alu_ready = 1'b1;
      @(negedge clk);
      phv_in_valid = 1'b0;
      @(negedge clk);
      alu_ready = 1'b0;
      chk("rst_pre_wait", alu_ready_in, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 16; t++) pt_model[t] = 16'h0;
      chk_reset_state("rst_wait");
      alu_result = 32'h1234; alu_result_valid = 1'b1;
      @(negedge clk);
      alu_result_valid = 1'b0;
      chk("rst_late_out_valid", phv_out_valid, 0);
      chk("rst_late_phv", phv_out, 0);
      chk("rst_late_in_ready", phv_in_ready, 1);
   endtask

   initial begin
      logic [255:0] p;
      logic [7:0]   op;
      logic [4:0]   a, b, c;
      rst_n = 1'b0; phv_in = '0; action_word_in = '0; vid_in = '0; phv_in_valid = 1'b0;
      cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0; alu_ready = 1'b0;
      alu_result = '0; alu_result_valid = 1'b0; phv_out_ready = 1'b0;
      for (int t = 0; t < 16; t++) pt_model[t] = 16'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk_reset_state("reset");

      // Add: c1 + c2 -> c3, 2-cycle ALU, no stalls.
      p = {8{$urandom}};
      p[32 +: 32] = 32'd5; p[64 +: 32] = 32'd7; p[96 +: 32] = 32'hAA;
      txn(p, mk_aw(8'h01, 5'd1, 5'd2, 5'd3, 16'h0), 4'd0, 0, 2, 0, 1'b0);

      // Addi: c1 + 0x10 -> c0; src2 is out of range but unused.
      p = {8{$urandom}};
      p[32 +: 32] = 32'd5;
      txn(p, mk_aw(8'h09, 5'd1, 5'd31, 5'd0, 16'h0010), 4'd1, 0, 2, 0, 1'b0);

      // Page table lookup with a rewrite of the active tenant during WAIT.
      cfg_write(4'd3, 16'h0408);
      txn({8{$urandom}}, mk_aw(8'h07, 5'd2, 5'd0, 5'd4, 16'h0003), 4'd3, 0, 2, 0, 1'b1);
      txn({8{$urandom}}, mk_aw(8'h07, 5'd2, 5'd0, 5'd4, 16'h0003), 4'd3, 0, 2, 0, 1'b0);

      // Backpressure on both sides.
      txn({8{$urandom}}, mk_aw(8'h02, 5'd4, 5'd5, 5'd6, 16'h0), 4'd2, 5, 2, 3, 1'b0);

      // No-op and illegal index.
      txn({8{$urandom}}, mk_aw(8'h00, 5'd1, 5'd2, 5'd3, 16'h0), 4'd0, 0, 1, 0, 1'b0);
      txn({8{$urandom}}, mk_aw(8'h01, 5'd9, 5'd2, 5'd3, 16'h0), 4'd0, 0, 1, 2, 1'b0);

      // Reset while waiting on the ALU, then a clean transaction from tenant 5.
      cfg_write(4'd5, 16'hBEEF);
      reset_in_wait();
      txn({8{$urandom}}, mk_aw(8'h01, 5'd1, 5'd2, 5'd3, 16'h0), 4'd5, 0, 2, 0, 1'b0);

      // Randomized traffic.
      for (int n = 0; n < 40; n++) begin
         p  = {8{$urandom}};
         op = ops[$urandom_range(0, 10)];
         a  = 5'($urandom_range(0, 7));
         b  = 5'($urandom_range(0, 7));
         c  = 5'($urandom_range(0, 7));
         if (op != 8'h00 && $urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 2))
               0:       a = 5'($urandom_range(8, 31));
               1:       b = 5'($urandom_range(8, 31));
               default: c = 5'($urandom_range(8, 31));
            endcase
         end
         if ($urandom_range(0, 3) == 0) cfg_write(4'($urandom), 16'($urandom));
         txn(p, mk_aw(op, a, b, c, 16'($urandom)), 4'($urandom),
             int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU action interface in one RMT action stage.
- Accepts one PHV plus its 64-bit action word per transaction.
- Selects operands from PHV containers, looks up the tenant page-table entry, and issues the action to one ALU with the action/ready handshake.
- Collects the ALU result, writes it into the destination container and emits the updated PHV downstream.

Parameters:
ACTION_LEN, 64, action word width; opcode at [63:56]
DATA_WIDTH, 32, container and operand width
NUM_CONT, 8, PHV containers; PHV width = NUM_CONT*DATA_WIDTH
NUM_TENANT, 16, page-table entries (vid index width 4)

Ports:
clk  in  1  clock
rst_n  in  1  reset: one clock; reset is synchronous and active-low
phv_in  in  NUM_CONT*DATA_WIDTH  input PHV; container k = bits [k*DATA_WIDTH +: DATA_WIDTH]
action_word_in  in  ACTION_LEN  action word for this PHV
vid_in  in  4  tenant id
phv_in_valid  in  1  input valid
phv_in_ready  out  1  input ready
cfg_wr_en  in  1  page-table write strobe
cfg_wr_addr  in  4  page-table index
cfg_wr_data  in  16  {addr_len[15:8], base_addr[7:0]}
action_out  out  ACTION_LEN  action to ALU
action_valid  out  1  issue strobe to ALU
operand_1_out  out  DATA_WIDTH  to ALU operand 1
operand_2_out  out  DATA_WIDTH  to ALU operand 2
operand_3_out  out  DATA_WIDTH  to ALU operand 3
alu_ready  in  1  ALU ready_out
page_tbl_out  out  16  tenant entry to ALU
page_tbl_out_valid  out  1  entry valid
alu_result  in  DATA_WIDTH  ALU container_out
alu_result_valid  in  1  ALU container_out_valid
alu_ready_in  out  1  result-accept ready to ALU
phv_out  out  NUM_CONT*DATA_WIDTH  updated PHV
phv_out_valid  out  1  output valid
phv_out_ready  in  1  downstream ready
action_err  out  1  one-cycle pulse on an illegal container index

Behaviour:
- Action word fields:
  - op = [63:56]
  - src1 = [55:51]
  - src2 = [50:46]
  - dst = [45:41]
  - imm16 = [40:25]
  - remaining bits ignored.
- Operand selection, registered at accept:
  - operand_1 = PHV[src1].
  - operand_2 = zero-extended imm16 for op in {0x09, 0x0A, 0x0E, 0x08, 0x0B, 0x07}; otherwise PHV[src2].
  - operand_3 = PHV[dst].
- States: IDLE, ISSUE, WAIT, OUT.
- IDLE:
  - phv_in_ready=1.
  - On phv_in_valid, capture PHV, action, vid and operands.
  - op==0x00 -> OUT, PHV unchanged.
  - Any used index >= NUM_CONT -> OUT, PHV unchanged, action_err pulses in the following cycle.
  - Used indices: src1, dst, and src2 only when not immediate.
  - Otherwise -> ISSUE.
- ISSUE:
  - action_valid = alu_ready, combinational from state; at most one cycle high per transaction.
  - The edge where action_valid=1 moves to WAIT.
  - alu_ready low holds ISSUE indefinitely.
- WAIT:
  - alu_ready_in=1.
  - On alu_result_valid, write alu_result into PHV[dst] and move to OUT.
  - alu_result in any other state is ignored.
- OUT:
  - phv_out_valid=1.
  - phv_out stays stable until phv_out_ready; the edge with phv_out_ready moves to IDLE.
- Hold rules:
  - action_out, operand_*_out and page_tbl_out stay stable from the accept edge until the edge leaving WAIT. The ALU RAM address depends on them combinationally.
  - page_tbl_out_valid=1 in ISSUE and WAIT, 0 elsewhere.
- Page table:
  - NUM_TENANT x 16 register array; a cfg write takes effect the next cycle.
  - page_tbl_out is registered from entry[vid] at accept.
  - A cfg write to the active vid mid-transaction does not alter the held page_tbl_out.
- Latency:
  - No-op or error: phv_out_valid at accept+1.
  - Issued action: with alu_ready=1 and a 2-cycle ALU, phv_out_valid at accept+4.
- Reset:
  - State -> IDLE; all registers and outputs 0 except phv_in_ready=1.
  - Page table cleared to 0.
  - An in-flight transaction is dropped with no phv_out.
- Throughput: one transaction in flight; no internal buffering.

Test Plan:
- Add: PHV c1=5, c2=7, c3=0xAA; op 0x01, src1=1, src2=2, dst=3. Required: one-cycle action_valid with operands 5/7/0xAA; ALU model returns 12; phv_out c3=12, other containers unchanged.
- Addi: op 0x09, src1=1 (c1=5), imm16=0x0010. Required: operand_2_out=16; ALU model returns 21 to dst=0; phv_out c0=21.
- Page table: cfg write vid 3 = 0x0408, then vid_in=3 with loadd op 0x07. Required: page_tbl_out=0x0408 and page_tbl_out_valid=1 from ISSUE through WAIT; a cfg rewrite of vid 3 during WAIT leaves page_tbl_out unchanged.
- Backpressure: alu_ready low 5 cycles, then phv_out_ready low 3 cycles. Required: no action_valid until alu_ready rises, exactly one issue, phv_out stable and valid for all 3 stalled cycles.
- No-op and error: op 0x00 gives phv_out==phv_in at accept+1 with no action_valid. Op 0x01 with src1=9 (NUM_CONT=8) gives action_err pulse, PHV passthrough, no issue.
- Reset in WAIT: rst_n low one cycle. Required: all outputs 0, phv_in_ready=1, a late alu_result_valid ignored, next transaction correct.
